// File: rtl/stack_uc_sequencer.sv
// ---------------------------------------------------------------------------
// stack_uc_sequencer
//
// This is the control unit of the stack processor. It fetches 16-bit
// instructions from a synchronous program ROM and decodes them. It then drives
// the datapath stack (pilha), the temp1/temp2 operand registers and the ULA
// through push, pop and binary-operation micro-sequences.
//
// Optional feature: define UC_SINGLE_STEP_EN to add the `step` input. With it
// defined, FETCH waits for step=1 before each instruction runs.
//
// Ports:
//   clock          in   system clock, rising edge
//   reset_UC       in   synchronous active-high reset
//   step           in   (UC_SINGLE_STEP_EN only) release one instruction
//   rom_data       in   ROM word, valid the cycle after a_rom
//   stack_full     in   pilha full flag
//   stack_empty    in   pilha empty flag
//   tos_zero       in   top of stack equals zero
//   a_rom          out  ROM address (the pc)
//   controle_pilha out  00 hold, 01 push din_UC, 10 push din_ULA, 11 pop
//   din_UC         out  immediate, sign-extended from ir[11:0]
//   sel_ula        out  ULA operation select (ir[14:12] in PUSHRES)
//   load_temp1     out  temp1 captures pilha dout
//   load_temp2     out  temp2 captures pilha dout
//   halted         out  in HALT
//   error          out  in ERROR
//   estado_atual   out  current state encoding
//
// The outputs come from flops. They are loaded from the next state and the
// next ir, so their values always match estado_atual. The stack flags are
// sampled at each edge. Those samples already include the push or pop that
// the same edge commits. An underflow or overflow is therefore known when the
// strobing state is entered. The unit enters that state with its strobes at 0
// and marks it faulted. The faulted state then moves to ERROR.
// ---------------------------------------------------------------------------
module stack_uc_sequencer #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 16,
  parameter int RESET_PC = 0
) (
  input  logic              clock,
  input  logic              reset_UC,
`ifdef UC_SINGLE_STEP_EN
  input  logic              step,
`endif
  input  logic [15:0]       rom_data,
  input  logic              stack_full,
  input  logic              stack_empty,
  input  logic              tos_zero,
  output logic [ADDR_W-1:0] a_rom,
  output logic [1:0]        controle_pilha,
  output logic [DATA_W-1:0] din_UC,
  output logic [2:0]        sel_ula,
  output logic              load_temp1,
  output logic              load_temp2,
  output logic              halted,
  output logic              error,
  output logic [2:0]        estado_atual
);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXEC    = 3'd2,
    S_POP1    = 3'd3,
    S_POP2    = 3'd4,
    S_PUSHRES = 3'd5,
    S_HALT    = 3'd6,
    S_ERROR   = 3'd7
  } state_t;

  localparam logic [ADDR_W-1:0] RESET_PC_C = ADDR_W'(RESET_PC);

  state_t            state_r, state_s;
  logic [ADDR_W-1:0] pc_r, pc_s;
  logic [15:0]       ir_r, ir_s;
  // fault_r: the current strobing state found an underflow/overflow on entry
  logic              fault_r, fault_s;

  logic [1:0]        ctl_s;
  logic              ld1_s;
  logic              ld2_s;
  logic [2:0]        sel_s;
  logic [DATA_W-1:0] din_s;

  assign a_rom = pc_r;

  // Next-state, pc and ir logic
  always_comb begin
    state_s = state_r;
    pc_s    = pc_r;
    ir_s    = ir_r;
    fault_s = 1'b0;
    case (state_r)
      S_FETCH: begin
`ifdef UC_SINGLE_STEP_EN
        if (step) begin
          state_s = S_DECODE;
        end else begin
          state_s = S_FETCH;
        end
`else
        state_s = S_DECODE;
`endif
      end
      S_DECODE: begin
        ir_s = rom_data;
        pc_s = pc_r + {{(ADDR_W-1){1'b0}}, 1'b1};
        case (rom_data[15:12])
          4'h0: state_s = S_FETCH;
          4'h1: begin
            state_s = S_EXEC;
            fault_s = stack_full;
          end
          4'h2: begin
            state_s = S_EXEC;
            fault_s = stack_empty;
          end
          4'h8, 4'h9, 4'hA, 4'hB, 4'hC: begin
            state_s = S_POP1;
            fault_s = stack_empty;
          end
          4'hD: begin
            pc_s    = rom_data[ADDR_W-1:0];
            state_s = S_FETCH;
          end
          4'hE: begin
            if (tos_zero) begin
              pc_s = rom_data[ADDR_W-1:0];
            end else begin
              pc_s = pc_r + {{(ADDR_W-1){1'b0}}, 1'b1};
            end
            state_s = S_FETCH;
          end
          4'hF:    state_s = S_HALT;
          default: state_s = S_ERROR;
        endcase
      end
      S_EXEC: begin
        if (fault_r) begin
          state_s = S_ERROR;
        end else begin
          state_s = S_FETCH;
        end
      end
      S_POP1: begin
        if (fault_r) begin
          state_s = S_ERROR;
        end else begin
          // The flag sampled here already includes this pop, so it shows
          // whether a second operand is left for POP2.
          state_s = S_POP2;
          fault_s = stack_empty;
        end
      end
      S_POP2: begin
        if (fault_r) begin
          state_s = S_ERROR;
        end else begin
          state_s = S_PUSHRES;
        end
      end
      S_PUSHRES: state_s = S_FETCH;
      S_HALT:    state_s = S_HALT;
      S_ERROR:   state_s = S_ERROR;
      default:   state_s = S_ERROR;
    endcase
  end

  // Output decode for the state being entered; the result is registered below
  always_comb begin
    ctl_s = 2'b00;
    ld1_s = 1'b0;
    ld2_s = 1'b0;
    sel_s = 3'd0;
    din_s = {{(DATA_W-12){ir_s[11]}}, ir_s[11:0]};
    case (state_s)
      S_EXEC: begin
        if (fault_s) begin
          ctl_s = 2'b00;
        end else if (ir_s[15:12] == 4'h1) begin
          ctl_s = 2'b01;
        end else begin
          ctl_s = 2'b11;
        end
      end
      S_POP1: begin
        if (fault_s) begin
          ctl_s = 2'b00;
        end else begin
          ctl_s = 2'b11;
          ld1_s = 1'b1;
        end
      end
      S_POP2: begin
        if (fault_s) begin
          ctl_s = 2'b00;
        end else begin
          ctl_s = 2'b11;
          ld2_s = 1'b1;
        end
      end
      S_PUSHRES: begin
        ctl_s = 2'b10;
        sel_s = ir_s[14:12];
      end
      default: begin
        ctl_s = 2'b00;
      end
    endcase
  end

  // State, pc, ir and registered outputs
  always_ff @(posedge clock) begin
    if (reset_UC) begin
      state_r        <= S_FETCH;
      pc_r           <= RESET_PC_C;
      ir_r           <= 16'h0000;
      fault_r        <= 1'b0;
      controle_pilha <= 2'b00;
      din_UC         <= {DATA_W{1'b0}};
      sel_ula        <= 3'd0;
      load_temp1     <= 1'b0;
      load_temp2     <= 1'b0;
      halted         <= 1'b0;
      error          <= 1'b0;
      estado_atual   <= 3'd0;
    end else begin
      state_r        <= state_s;
      pc_r           <= pc_s;
      ir_r           <= ir_s;
      fault_r        <= fault_s;
      controle_pilha <= ctl_s;
      din_UC         <= din_s;
      sel_ula        <= sel_s;
      load_temp1     <= ld1_s;
      load_temp2     <= ld2_s;
      halted         <= (state_s == S_HALT);
      error          <= (state_s == S_ERROR);
      estado_atual   <= state_s;
    end
  end

endmodule

// File: tb/tb_stack_uc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_stack_uc_sequencer
//
// Directed testbench for stack_uc_sequencer. It models a synchronous ROM, a
// 16-deep pilha, the temp1/temp2 registers and the ULA. The pilha flags show
// the committed stack state, and that state includes the operation strobed at
// the current edge.
// ---------------------------------------------------------------------------
module tb_stack_uc_sequencer;

  localparam int DEPTH = 16;

  logic        clock = 1'b0;
  logic        reset_UC = 1'b1;
`ifdef UC_SINGLE_STEP_EN
  logic        step = 1'b1;
`endif
  logic [15:0] rom_data;
  logic        stack_full, stack_empty, tos_zero;
  logic [7:0]  a_rom;
  logic [1:0]  controle_pilha;
  logic [15:0] din_UC;
  logic [2:0]  sel_ula;
  logic        load_temp1, load_temp2, halted, error;
  logic [2:0]  estado_atual;

  logic [15:0] rom [256];
  logic [15:0] stk [DEPTH];
  int          cnt, cnt_next;
  logic [15:0] temp1 = 16'h0000;
  logic [15:0] temp2 = 16'h0000;
  logic [15:0] ula, top;
  logic        tz_ovr_en = 1'b0;
  logic        tz_ovr_val = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  stack_uc_sequencer dut (
    .clock(clock), .reset_UC(reset_UC),
`ifdef UC_SINGLE_STEP_EN
    .step(step),
`endif
    .rom_data(rom_data), .stack_full(stack_full), .stack_empty(stack_empty),
    .tos_zero(tos_zero), .a_rom(a_rom), .controle_pilha(controle_pilha),
    .din_UC(din_UC), .sel_ula(sel_ula), .load_temp1(load_temp1),
    .load_temp2(load_temp2), .halted(halted), .error(error),
    .estado_atual(estado_atual)
  );

  // Synchronous ROM
  always @(posedge clock) rom_data <= rom[a_rom];

  // ULA: a = temp2, b = temp1
  always_comb begin
    case (sel_ula)
      3'd0:    ula = temp2 + temp1;
      3'd1:    ula = temp2 - temp1;
      3'd2:    ula = temp2 & temp1;
      3'd3:    ula = temp2 | temp1;
      3'd4:    ula = temp2 ^ temp1;
      default: ula = 16'h0000;
    endcase
  end

  // Flags as committed by the current edge
  always_comb begin
    top = 16'h0000;
    if (cnt > 0) top = stk[cnt-1];
    cnt_next = cnt;
    if (controle_pilha == 2'b01 || controle_pilha == 2'b10) cnt_next = cnt + 1;
    else if (controle_pilha == 2'b11) cnt_next = cnt - 1;
    stack_full  = (cnt_next >= DEPTH);
    stack_empty = (cnt_next <= 0);
    tos_zero    = tz_ovr_en ? tz_ovr_val : ((cnt > 0) && (top == 16'h0000));
  end

  // Pilha and temp registers
  always @(posedge clock) begin
    if (reset_UC) begin
      cnt <= 0;
    end else begin
      case (controle_pilha)
        2'b01: if (cnt < DEPTH) begin stk[cnt] <= din_UC; cnt <= cnt + 1; end
        2'b10: if (cnt < DEPTH) begin stk[cnt] <= ula; cnt <= cnt + 1; end
        2'b11: if (cnt > 0) cnt <= cnt - 1;
        default: ;
      endcase
      if (load_temp1 && cnt > 0) temp1 <= stk[cnt-1];
      if (load_temp2 && cnt > 0) temp2 <= stk[cnt-1];
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic rom_clear();
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
  endtask

  // Leaves the bench at the negedge after the reset edge (state FETCH, cycle 0)
  task automatic do_reset();
    @(negedge clock);
    reset_UC = 1'b1;
    @(negedge clock);
    reset_UC = 1'b0;
  endtask

  task automatic test_reset();
    rom_clear();
    do_reset();
    vectors++; if (estado_atual !== 3'd0) begin miscompares++; $display("FAIL reset_state: got %0d expected 0", estado_atual); end
    vectors++; if (a_rom !== 8'h00) begin miscompares++; $display("FAIL reset_pc: got %h expected 00", a_rom); end
    vectors++; if ({controle_pilha, load_temp1, load_temp2, halted, error} !== 6'b0) begin
      miscompares++; $display("FAIL reset_strobes: got %b expected 000000", {controle_pilha, load_temp1, load_temp2, halted, error}); end
  endtask

  task automatic test_push_add();
    logic [2:0] exp_st [14];
    logic [1:0] exp_ctl [14];
    exp_st  = '{3'd0,3'd1,3'd2,3'd0,3'd1,3'd2,3'd0,3'd1,3'd3,3'd4,3'd5,3'd0,3'd1,3'd6};
    exp_ctl = '{2'd0,2'd0,2'd1,2'd0,2'd0,2'd1,2'd0,2'd0,2'd3,2'd3,2'd2,2'd0,2'd0,2'd0};
    rom_clear();
    rom[0] = 16'h1005; rom[1] = 16'h1003; rom[2] = 16'h8000; rom[3] = 16'hF000;
    do_reset();
    for (int k = 0; k < 14; k++) begin
      vectors++; if (estado_atual !== exp_st[k]) begin miscompares++; $display("FAIL add_state[%0d]: got %0d expected %0d", k, estado_atual, exp_st[k]); end
      vectors++; if (controle_pilha !== exp_ctl[k]) begin miscompares++; $display("FAIL add_ctl[%0d]: got %b expected %b", k, controle_pilha, exp_ctl[k]); end
      if (k == 2) begin
        vectors++; if (din_UC !== 16'h0005) begin miscompares++; $display("FAIL add_din: got %h expected 0005", din_UC); end
      end
      if (k == 12) begin
        vectors++; if (halted !== 1'b0) begin miscompares++; $display("FAIL add_early_halt: got %b expected 0", halted); end
      end
      if (k < 13) tick(1);
    end
    vectors++; if (halted !== 1'b1) begin miscompares++; $display("FAIL add_halted: got %b expected 1", halted); end
    vectors++; if (cnt !== 1 || top !== 16'h0008) begin miscompares++; $display("FAIL add_result: got cnt=%0d top=%h expected cnt=1 top=0008", cnt, top); end
    tick(6);
    vectors++; if (a_rom !== 8'h04 || halted !== 1'b1 || controle_pilha !== 2'b00) begin
      miscompares++; $display("FAIL add_halt_sticky: got a_rom=%h halted=%b ctl=%b expected 04 1 00", a_rom, halted, controle_pilha); end
  endtask

  task automatic test_sub();
    rom_clear();
    rom[0] = 16'h1002; rom[1] = 16'h1007; rom[2] = 16'h9000; rom[3] = 16'hF000;
    do_reset();
    tick(10);
    vectors++; if (estado_atual !== 3'd5 || sel_ula !== 3'd1) begin
      miscompares++; $display("FAIL sub_pushres: got state=%0d sel=%0d expected 5 1", estado_atual, sel_ula); end
    tick(3);
    vectors++; if (temp1 !== 16'h0007 || temp2 !== 16'h0002) begin
      miscompares++; $display("FAIL sub_temps: got t1=%h t2=%h expected 0007 0002", temp1, temp2); end
    vectors++; if (top !== 16'hFFFB || halted !== 1'b1) begin
      miscompares++; $display("FAIL sub_result: got top=%h halted=%b expected FFFB 1", top, halted); end
    rom_clear();
    rom[0] = 16'h1FFF; rom[1] = 16'hF000;
    do_reset();
    tick(2);
    vectors++; if (din_UC !== 16'hFFFF || controle_pilha !== 2'b01) begin
      miscompares++; $display("FAIL sext_din: got din=%h ctl=%b expected FFFF 01", din_UC, controle_pilha); end
  endtask

  task automatic test_underflow();
    int pops;
    pops = 0;
    rom_clear();
    rom[0] = 16'h8000;
    do_reset();
    tick(2);
    vectors++; if (estado_atual !== 3'd3 || controle_pilha !== 2'b00 || load_temp1 !== 1'b0) begin
      miscompares++; $display("FAIL uf_pop1: got state=%0d ctl=%b ld1=%b expected 3 00 0", estado_atual, controle_pilha, load_temp1); end
    for (int k = 0; k < 21; k++) begin
      tick(1);
      if (controle_pilha != 2'b00) pops++;
    end
    vectors++; if (estado_atual !== 3'd7 || error !== 1'b1 || a_rom !== 8'h01) begin
      miscompares++; $display("FAIL uf_error_sticky: got state=%0d err=%b a_rom=%h expected 7 1 01", estado_atual, error, a_rom); end
    vectors++; if (pops !== 0) begin miscompares++; $display("FAIL uf_no_strobe: got %0d strobe cycles expected 0", pops); end
    do_reset();
    vectors++; if (estado_atual !== 3'd0 || a_rom !== 8'h00 || error !== 1'b0) begin
      miscompares++; $display("FAIL uf_recover: got state=%0d a_rom=%h err=%b expected 0 00 0", estado_atual, a_rom, error); end
  endtask

  task automatic test_faults();
    // POP2 underflow: only one operand on the stack
    rom_clear();
    rom[0] = 16'h1001; rom[1] = 16'h8000;
    do_reset();
    tick(5);
    vectors++; if (estado_atual !== 3'd3 || controle_pilha !== 2'b11) begin
      miscompares++; $display("FAIL uf2_pop1: got state=%0d ctl=%b expected 3 11", estado_atual, controle_pilha); end
    tick(1);
    vectors++; if (estado_atual !== 3'd4 || controle_pilha !== 2'b00 || load_temp2 !== 1'b0) begin
      miscompares++; $display("FAIL uf2_pop2: got state=%0d ctl=%b ld2=%b expected 4 00 0", estado_atual, controle_pilha, load_temp2); end
    tick(1);
    vectors++; if (estado_atual !== 3'd7 || cnt !== 0) begin
      miscompares++; $display("FAIL uf2_error: got state=%0d cnt=%0d expected 7 0", estado_atual, cnt); end
    // POP on an empty stack
    rom_clear();
    rom[0] = 16'h2000;
    do_reset();
    tick(2);
    vectors++; if (estado_atual !== 3'd2 || controle_pilha !== 2'b00) begin
      miscompares++; $display("FAIL pop_empty_exec: got state=%0d ctl=%b expected 2 00", estado_atual, controle_pilha); end
    tick(1);
    vectors++; if (error !== 1'b1) begin miscompares++; $display("FAIL pop_empty_err: got %b expected 1", error); end
    // Illegal opcode
    rom_clear();
    rom[0] = 16'h3000;
    do_reset();
    tick(2);
    vectors++; if (estado_atual !== 3'd7) begin miscompares++; $display("FAIL illegal_op: got %0d expected 7", estado_atual); end
    // Overflow on the 17th push
    rom_clear();
    for (int i = 0; i < 17; i++) rom[i] = 16'h1001;
    do_reset();
    tick(50);
    vectors++; if (estado_atual !== 3'd2 || controle_pilha !== 2'b00) begin
      miscompares++; $display("FAIL ovf_exec: got state=%0d ctl=%b expected 2 00", estado_atual, controle_pilha); end
    tick(1);
    vectors++; if (estado_atual !== 3'd7 || cnt !== DEPTH) begin
      miscompares++; $display("FAIL ovf_error: got state=%0d cnt=%0d expected 7 16", estado_atual, cnt); end
  endtask

  task automatic test_jumps();
    rom_clear();
    rom[0] = 16'h1000; rom[1] = 16'hE010;
    do_reset();
    tick(5);
    vectors++; if (estado_atual !== 3'd0 || a_rom !== 8'h10 || cnt !== 1) begin
      miscompares++; $display("FAIL jz_taken: got state=%0d a_rom=%h cnt=%0d expected 0 10 1", estado_atual, a_rom, cnt); end
    tz_ovr_en = 1'b1; tz_ovr_val = 1'b0;
    do_reset();
    tick(5);
    vectors++; if (a_rom !== 8'h02) begin miscompares++; $display("FAIL jz_not_taken: got %h expected 02", a_rom); end
    tz_ovr_en = 1'b0;
    rom_clear();
    rom[0] = 16'hD0FF;
    do_reset();
    tick(2);
    vectors++; if (a_rom !== 8'hFF) begin miscompares++; $display("FAIL jmp_target: got %h expected FF", a_rom); end
    tick(2);
    vectors++; if (a_rom !== 8'h00 || estado_atual !== 3'd0) begin
      miscompares++; $display("FAIL pc_wrap: got a_rom=%h state=%0d expected 00 0", a_rom, estado_atual); end
  endtask

  task automatic test_reset_mid();
    rom_clear();
    rom[0] = 16'h1004; rom[1] = 16'h1006; rom[2] = 16'hA000;
    do_reset();
    tick(9);
    vectors++; if (estado_atual !== 3'd4 || load_temp2 !== 1'b1) begin
      miscompares++; $display("FAIL mid_pop2: got state=%0d ld2=%b expected 4 1", estado_atual, load_temp2); end
    reset_UC = 1'b1;
    tick(1);
    vectors++; if (estado_atual !== 3'd0 || {controle_pilha, load_temp1, load_temp2} !== 4'b0 || a_rom !== 8'h00) begin
      miscompares++; $display("FAIL mid_reset: got state=%0d strobes=%b a_rom=%h expected 0 0000 00",
                              estado_atual, {controle_pilha, load_temp1, load_temp2}, a_rom); end
    reset_UC = 1'b0;
  endtask

`ifdef UC_SINGLE_STEP_EN
  task automatic test_single_step();
    int moved;
    moved = 0;
    rom_clear();
    rom[0] = 16'h1009; rom[1] = 16'h1009;
    step = 1'b0;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      tick(1);
      if (estado_atual != 3'd0 || a_rom != 8'h00 || controle_pilha != 2'b00) moved++;
    end
    vectors++; if (moved !== 0) begin miscompares++; $display("FAIL step_hold: got %0d bad cycles expected 0", moved); end
    step = 1'b1;
    tick(1);
    step = 1'b0;
    tick(1);
    vectors++; if (estado_atual !== 3'd2 || controle_pilha !== 2'b01) begin
      miscompares++; $display("FAIL step_exec: got state=%0d ctl=%b expected 2 01", estado_atual, controle_pilha); end
    tick(5);
    vectors++; if (estado_atual !== 3'd0 || a_rom !== 8'h01 || cnt !== 1) begin
      miscompares++; $display("FAIL step_one: got state=%0d a_rom=%h cnt=%0d expected 0 01 1", estado_atual, a_rom, cnt); end
    step = 1'b1;
  endtask
`endif

  initial begin
    rom_clear();
    test_reset();
    test_push_add();
    test_sub();
    test_underflow();
    test_faults();
    test_jumps();
    test_reset_mid();
`ifdef UC_SINGLE_STEP_EN
    test_single_step();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
